// File: rtl/meas_result_reader_if.sv
// Result-read bus between the measurement demodulator / result consumer and
// meas_result_reader. The slave modport is the reader itself. The master
// modport is whatever drives the demodulator strobes and consumes the FIFO head.
interface meas_result_reader_if #(
   parameter int DEPTH = 16,
   parameter int SW    = 16
);
   localparam int AW = $clog2(DEPTH);

   // demodulator side
   logic          done;
   logic [31:0]   xacc;
   logic [31:0]   yacc;
   logic          resultx;
   logic          resulty;
   logic          clear;

   // consumer side
   logic          out_ready;
   logic          out_valid;
   logic [SW-1:0] out_seq;
   logic [31:0]   out_xacc;
   logic [31:0]   out_yacc;
   logic [1:0]    out_bits;
   logic [AW:0]   level;
   logic          overflow;
   logic [15:0]   drop_cnt;

   modport master (
      output done, xacc, yacc, resultx, resulty, clear, out_ready,
      input  out_valid, out_seq, out_xacc, out_yacc, out_bits, level,
             overflow, drop_cnt
   );

   modport slave (
      input  done, xacc, yacc, resultx, resulty, clear, out_ready,
      output out_valid, out_seq, out_xacc, out_yacc, out_bits, level,
             overflow, drop_cnt
   );
endinterface

// File: rtl/meas_result_reader.sv
// Measurement result reader: captures each done strobe from the demodulator,
// stamps it with a shot sequence number and queues it in a first-word-fall-
// through FIFO. The FIFO is split into a registered head stage (what the
// consumer sees) and a backing array that holds everything behind the head.
// level counts both, so the array only ever holds up to DEPTH-1 entries.
module meas_result_reader #(
   parameter  int DEPTH = 16,
   parameter  int SW    = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input logic                 clk,
   input logic                 reset,
   meas_result_reader_if.slave bus
);

   // Entry layout: {seq, resulty, resultx, yacc, xacc}
   localparam int EW = SW + 2 + 64;

   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [SW-1:0] SEQ_ONE  = SW'(1);

   // backing store behind the head stage (no reset: contents are don't-care)
   logic [EW-1:0] mem [DEPTH];

   // state registers
   logic [EW-1:0] head_q,     head_d;
   logic          valid_q,    valid_d;
   logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
   logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
   logic [AW:0]   level_q,    level_d;
   logic [SW-1:0] seq_q,      seq_d;
   logic          overflow_q, overflow_d;
   logic [15:0]   drop_cnt_q, drop_cnt_d;

   // array write port
   logic          ram_we;
   logic [EW-1:0] entry_in;

   // event decode; clear masks both the write and the pop
   logic full;
   logic ram_empty;
   logic push;
   logic pop;
   logic accept;
   logic drop;

   assign entry_in  = {seq_q, bus.resulty, bus.resultx, bus.yacc, bus.xacc};

   assign full      = (level_q == LVL_FULL);
   // Nothing behind the head when level is 0 or 1.
   assign ram_empty = (level_q <= LVL_ONE);
   assign push      = bus.done & ~bus.clear;
   assign pop       = valid_q & bus.out_ready & ~bus.clear;
   // A pop in the same cycle frees the slot a full FIFO needs.
   assign accept    = push & (~full | pop);
   assign drop      = push & full & ~pop;

   // Next-state for head stage, pointers, level, shot counter and drop stats
   always_comb begin
      head_d     = head_q;
      valid_d    = valid_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      level_d    = level_q;
      seq_d      = seq_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      ram_we     = 1'b0;

      if (bus.clear) begin
         head_d     = '0;
         valid_d    = 1'b0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         level_d    = '0;
         seq_d      = '0;
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end else begin
         // every done consumes a shot number, even when it is dropped
         if (bus.done) begin
            seq_d = seq_q + SEQ_ONE;
         end

         if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
               drop_cnt_d = drop_cnt_q + 16'd1;
            end
         end

         if (pop) begin
            if (ram_empty) begin
               // head was the only entry: refill straight from the input
               // if a new result arrives, otherwise go empty
               if (accept) begin
                  head_d = entry_in;
               end else begin
                  valid_d = 1'b0;
               end
            end else begin
               // advance: next queued entry moves into the head stage
               head_d   = mem[rd_ptr_q];
               rd_ptr_d = rd_ptr_q + PTR_ONE;
               if (accept) begin
                  ram_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + PTR_ONE;
               end
            end
         end else if (accept) begin
            if (!valid_q) begin
               // empty FIFO: load the head directly so it shows next cycle
               head_d  = entry_in;
               valid_d = 1'b1;
            end else begin
               ram_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
         end

         // level moves only when exactly one of write/pop happens
         case ({accept, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
      end
   end

   // Register all state; async reset returns the block to empty
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q     <= '0;
         valid_q    <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         level_q    <= '0;
         seq_q      <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         head_q     <= head_d;
         valid_q    <= valid_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         level_q    <= level_d;
         seq_q      <= seq_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Backing array write port
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[wr_ptr_q] <= entry_in;
      end
   end

   // All outputs come straight from registers
   assign bus.out_valid = valid_q;
   assign bus.out_seq   = head_q[EW-1 -: SW];
   assign bus.out_bits  = head_q[65:64];
   assign bus.out_yacc  = head_q[63:32];
   assign bus.out_xacc  = head_q[31:0];
   assign bus.level     = level_q;
   assign bus.overflow  = overflow_q;
   assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_meas_result_reader.sv
// Directed testbench for meas_result_reader: reset, overflow/drop, full with
// simultaneous pop, random back-pressure scoreboard, sequence wrap, and
// async reset / clear behaviour.
module tb_meas_result_reader;

   logic clk;
   logic reset;

   int tests_run;
   int tests_failed;

   meas_result_reader_if #(.DEPTH(16), .SW(16)) bus ();

   meas_result_reader #(.DEPTH(16), .SW(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] seq;
      logic [31:0] x;
   } exp_t;

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.done      = 1'b0;
      bus.xacc      = '0;
      bus.yacc      = '0;
      bus.resultx   = 1'b0;
      bus.resulty   = 1'b0;
      bus.clear     = 1'b0;
      bus.out_ready = 1'b0;
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
   endtask

   // reset state, then a single result with latency 1
   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      tick();
      tick();
      tests_run++;
      if ({bus.out_valid, bus.level, bus.overflow, bus.drop_cnt, bus.out_seq} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: valid=%0b level=%0d ovf=%0b drops=%0d seq=%0d required all 0",
                  bus.out_valid, bus.level, bus.overflow, bus.drop_cnt, bus.out_seq);
      end
      reset = 1'b0;
      tick();
      bus.done    = 1'b1;
      bus.xacc    = 32'h0000_1234;
      bus.yacc    = -32'sd5;
      bus.resulty = 1'b1;
      bus.resultx = 1'b0;
      tick();
      idle_inputs();
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_seq !== 16'd0 || bus.level !== 5'd1) begin
         tests_failed++;
         $display("FAIL single_head: valid=%0b seq=%0d level=%0d required 1/0/1",
                  bus.out_valid, bus.out_seq, bus.level);
      end
      tests_run++;
      if (bus.out_xacc !== 32'h0000_1234 || bus.out_yacc !== 32'hFFFF_FFFB || bus.out_bits !== 2'b10) begin
         tests_failed++;
         $display("FAIL single_fields: xacc=%h yacc=%h bits=%b required 00001234/fffffffb/10",
                  bus.out_xacc, bus.out_yacc, bus.out_bits);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      tests_run++;
      if (bus.out_valid !== 1'b0 || bus.level !== 5'd0) begin
         tests_failed++;
         $display("FAIL single_pop: valid=%0b level=%0d required 0/0", bus.out_valid, bus.level);
      end
      $display("[TB] test_reset done");
   endtask

   // 20 dones into a 16-deep FIFO with no consumer
   task automatic test_overflow();
      do_clear();
      for (int i = 0; i < 20; i++) begin
         bus.done = 1'b1;
         bus.xacc = 32'h100 + i;
         bus.yacc = 32'h200 + i;
         tick();
      end
      bus.done = 1'b0;
      tests_run++;
      if (bus.level !== 5'd16 || bus.overflow !== 1'b1 || bus.drop_cnt !== 16'd4) begin
         tests_failed++;
         $display("FAIL overflow_state: level=%0d ovf=%0b drops=%0d required 16/1/4",
                  bus.level, bus.overflow, bus.drop_cnt);
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tests_run++;
         if (bus.out_valid !== 1'b1 || bus.out_seq !== 16'(i) || bus.out_xacc !== 32'h100 + i) begin
            tests_failed++;
            $display("FAIL overflow_drain[%0d]: valid=%0b seq=%0d xacc=%h required 1/%0d/%h",
                     i, bus.out_valid, bus.out_seq, bus.out_xacc, i, 32'h100 + i);
         end
         tick();
      end
      bus.out_ready = 1'b0;
      tests_run++;
      if (bus.out_valid !== 1'b0 || bus.level !== 5'd0) begin
         tests_failed++;
         $display("FAIL overflow_empty: valid=%0b level=%0d required 0/0", bus.out_valid, bus.level);
      end
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_seq !== 16'd20) begin
         tests_failed++;
         $display("FAIL overflow_next_seq: valid=%0b seq=%0d required 1/20", bus.out_valid, bus.out_seq);
      end
      $display("[TB] test_overflow done");
   endtask

   // full FIFO with a done and a pop in the same cycle
   task automatic test_full_push_pop();
      do_clear();
      for (int i = 0; i < 16; i++) begin
         bus.done = 1'b1;
         bus.xacc = 32'hA000 + i;
         tick();
      end
      bus.done      = 1'b1;
      bus.xacc      = 32'hA000 + 16;
      bus.out_ready = 1'b1;
      tick();
      bus.done      = 1'b0;
      tests_run++;
      if (bus.level !== 5'd16 || bus.overflow !== 1'b0 || bus.drop_cnt !== 16'd0 || bus.out_seq !== 16'd1) begin
         tests_failed++;
         $display("FAIL full_pushpop: level=%0d ovf=%0b drops=%0d seq=%0d required 16/0/0/1",
                  bus.level, bus.overflow, bus.drop_cnt, bus.out_seq);
      end
      for (int i = 1; i <= 16; i++) begin
         tests_run++;
         if (bus.out_valid !== 1'b1 || bus.out_seq !== 16'(i) || bus.out_xacc !== 32'hA000 + i) begin
            tests_failed++;
            $display("FAIL full_drain[%0d]: valid=%0b seq=%0d xacc=%h required 1/%0d/%h",
                     i, bus.out_valid, bus.out_seq, bus.out_xacc, i, 32'hA000 + i);
         end
         tick();
      end
      bus.out_ready = 1'b0;
      tests_run++;
      if (bus.out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_empty: valid=%0b required 0", bus.out_valid);
      end
      $display("[TB] test_full_push_pop done");
   endtask

   // done every cycle, random back-pressure, scoreboard ordering
   task automatic test_random_backpressure();
      exp_t        q[$];
      logic [15:0] model_seq;
      int          drops;
      int          errs;
      bit          r;
      bit          popping;
      logic [31:0] xv;
      do_clear();
      model_seq = 16'd0;
      drops     = 0;
      errs      = 0;
      for (int c = 0; c < 1000; c++) begin
         tests_run++;
         if (bus.level !== 5'(q.size()) || bus.out_valid !== (q.size() > 0)) begin
            tests_failed++;
            errs++;
            $display("FAIL rand_level[%0d]: level=%0d valid=%0b required %0d/%0b",
                     c, bus.level, bus.out_valid, q.size(), q.size() > 0);
         end else if (q.size() > 0) begin
            tests_run++;
            if (bus.out_seq !== q[0].seq || bus.out_xacc !== q[0].x || bus.out_yacc !== ~q[0].x) begin
               tests_failed++;
               errs++;
               $display("FAIL rand_head[%0d]: seq=%0d xacc=%h required %0d/%h",
                        c, bus.out_seq, bus.out_xacc, q[0].seq, q[0].x);
            end
         end
         r  = 1'($urandom_range(0, 1));
         xv = $urandom;
         bus.done      = 1'b1;
         bus.xacc      = xv;
         bus.yacc      = ~xv;
         bus.out_ready = r;
         popping = (q.size() > 0) && r;
         if (popping) void'(q.pop_front());
         if (q.size() < 16) q.push_back('{model_seq, xv});
         else drops++;
         model_seq++;
         tick();
      end
      bus.done      = 1'b0;
      bus.out_ready = 1'b0;
      tests_run++;
      if (bus.drop_cnt !== 16'(drops) || bus.overflow !== (drops > 0)) begin
         tests_failed++;
         $display("FAIL rand_drops: drops=%0d ovf=%0b required %0d/%0b",
                  bus.drop_cnt, bus.overflow, drops, drops > 0);
      end
      bus.out_ready = 1'b1;
      while (q.size() > 0) begin
         tests_run++;
         if (bus.out_valid !== 1'b1 || bus.out_seq !== q[0].seq || bus.out_xacc !== q[0].x) begin
            tests_failed++;
            $display("FAIL rand_drain: valid=%0b seq=%0d xacc=%h required 1/%0d/%h",
                     bus.out_valid, bus.out_seq, bus.out_xacc, q[0].seq, q[0].x);
         end
         void'(q.pop_front());
         tick();
      end
      bus.out_ready = 1'b0;
      tests_run++;
      if (bus.out_valid !== 1'b0 || bus.level !== 5'd0) begin
         tests_failed++;
         $display("FAIL rand_empty: valid=%0b level=%0d required 0/0", bus.out_valid, bus.level);
      end
      $display("[TB] test_random_backpressure done, %0d drops modelled, %0d errors", drops, errs);
   endtask

   // shot counter wraps FFFF -> 0000
   task automatic test_seq_wrap();
      do_clear();
      bus.out_ready = 1'b1;
      bus.done      = 1'b1;
      for (int i = 0; i < 65535; i++) begin
         bus.xacc = i;
         tick();
      end
      bus.done = 1'b0;
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_seq !== 16'hFFFE || bus.level !== 5'd1) begin
         tests_failed++;
         $display("FAIL wrap_stream: valid=%0b seq=%h level=%0d required 1/fffe/1",
                  bus.out_valid, bus.out_seq, bus.level);
      end
      tick();
      bus.out_ready = 1'b0;
      bus.done      = 1'b1;
      bus.xacc      = 32'h5555;
      tick();
      bus.xacc      = 32'h6666;
      tick();
      bus.done      = 1'b0;
      tests_run++;
      if (bus.level !== 5'd2 || bus.out_seq !== 16'hFFFF || bus.out_xacc !== 32'h5555) begin
         tests_failed++;
         $display("FAIL wrap_ffff: level=%0d seq=%h xacc=%h required 2/ffff/5555",
                  bus.level, bus.out_seq, bus.out_xacc);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_seq !== 16'h0000 || bus.out_xacc !== 32'h6666) begin
         tests_failed++;
         $display("FAIL wrap_0000: valid=%0b seq=%h xacc=%h required 1/0000/6666",
                  bus.out_valid, bus.out_seq, bus.out_xacc);
      end
      $display("[TB] test_seq_wrap done");
   endtask

   // async reset mid-burst, then clear racing a done
   task automatic test_reset_and_clear();
      do_clear();
      for (int i = 0; i < 5; i++) begin
         bus.done = 1'b1;
         bus.xacc = 32'hC0 + i;
         tick();
      end
      #2;
      reset = 1'b1;
      #1;
      tests_run++;
      if ({bus.out_valid, bus.level, bus.overflow, bus.drop_cnt, bus.out_seq, bus.out_xacc} !== '0) begin
         tests_failed++;
         $display("FAIL async_reset: valid=%0b level=%0d seq=%0d xacc=%h required all 0",
                  bus.out_valid, bus.level, bus.out_seq, bus.out_xacc);
      end
      bus.done = 1'b0;
      tick();
      reset = 1'b0;
      bus.done = 1'b1;
      bus.xacc = 32'hD0;
      tick();
      bus.done = 1'b0;
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_seq !== 16'd0 || bus.level !== 5'd1 || bus.out_xacc !== 32'hD0) begin
         tests_failed++;
         $display("FAIL post_reset: valid=%0b seq=%0d level=%0d xacc=%h required 1/0/1/d0",
                  bus.out_valid, bus.out_seq, bus.level, bus.out_xacc);
      end
      bus.done = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      bus.clear = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.clear = 1'b0;
      bus.done  = 1'b0;
      bus.out_ready = 1'b0;
      tests_run++;
      if ({bus.out_valid, bus.level, bus.overflow, bus.drop_cnt, bus.out_seq, bus.out_xacc} !== '0) begin
         tests_failed++;
         $display("FAIL clear_with_done: valid=%0b level=%0d seq=%0d xacc=%h required all 0",
                  bus.out_valid, bus.level, bus.out_seq, bus.out_xacc);
      end
      bus.done = 1'b1;
      bus.xacc = 32'd77;
      tick();
      bus.done = 1'b0;
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_seq !== 16'd0 || bus.level !== 5'd1 || bus.out_xacc !== 32'd77) begin
         tests_failed++;
         $display("FAIL post_clear: valid=%0b seq=%0d level=%0d xacc=%0d required 1/0/1/77",
                  bus.out_valid, bus.out_seq, bus.level, bus.out_xacc);
      end
      $display("[TB] test_reset_and_clear done");
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b1;
      idle_inputs();
      test_reset();
      test_overflow();
      test_full_push_pop();
      test_random_backpressure();
      test_seq_wrap();
      test_reset_and_clear();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
